lsu_mem_master: RTL and testbench

- Load/store initiator that sits between the CPU datapath and the word-addressed data RAM.
- Accepts one byte-addressed load or store request at a time and drives the RAM-side enable/write/address/data with an ack handshake.
- Performs read-modify-write for byte and halfword stores.
- Aligns and sign/zero-extends load data and flags misaligned or out-of-range accesses.

---
 rtl/lsu_mem_master.sv | 143 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the CPU datapath and a word-addressed 32-bit RAM.
// Handles byte/halfword stores by read-modify-write and extends sub-word load data.
module lsu_mem_master #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_we;
   logic                r_signed;
   logic [1:0]          r_size;
   logic [1:0]          r_lane;
   logic [15:0]         r_wdata;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic [31:0]         r_resp_rdata;
   logic                r_resp_err;

   logic                w_accept;
   logic                w_err;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_load;
   logic [31:0]         w_merge;

   assign w_accept = (r_state == S_IDLE) && req_valid;
   assign w_err    = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                   || (|req_addr[31:ADDR_W+2]);

   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

   // Little-endian lane extraction and merge on the word returned by the RAM
   always_comb begin
      w_byte  = mem_rdata[{r_lane, 3'b000} +: 8];
      w_half  = mem_rdata[{r_lane[1], 4'b0000} +: 16];
      w_merge = mem_rdata;
      unique case (r_size)
         2'b00: begin
            w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
         end
         2'b01: begin
            w_load = {{16{r_signed & w_half[15]}}, w_half};
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
         end
         default: w_load = mem_rdata;
      endcase
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_err)                                w_next = S_RESP;
               else if (req_we && (req_size == 2'b10))   w_next = S_WR;
               else                                      w_next = S_RD;
            end
         end
         S_RD: begin
            mem_en = 1'b1;
            if (mem_ack) w_next = r_we ? S_WR : S_RESP;
         end
         S_WR: begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            if (mem_ack) w_next = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            w_next     = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_signed     <= 1'b0;
         r_size       <= '0;
         r_lane       <= '0;
         r_wdata      <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we         <= req_we;
            r_signed     <= req_signed;
            r_size       <= req_size;
            r_lane       <= req_addr[1:0];
            r_wdata      <= req_wdata[15:0];
            r_resp_err   <= w_err;
            r_resp_rdata <= '0;
            // Errored requests never reach the RAM, so its address/data are left alone
            if (!w_err) begin
               r_mem_addr <= req_addr[ADDR_W+1:2];
               if (req_we && (req_size == 2'b10)) r_mem_wdata <= req_wdata;
            end
         end
         if ((r_state == S_RD) && mem_ack) begin
            if (r_we) r_mem_wdata  <= w_merge;
            else      r_resp_rdata <= w_load;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed table, hand-written corner
// sequences and randomized requests against a behavioural memory/access model.
module tb_lsu_mem_master;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          clr;
   logic          req_valid, req_we, req_signed;
   logic [1:0]    req_size;
   logic [31:0]   req_addr, req_wdata;
   logic          req_ready, resp_valid, resp_err;
   logic [31:0]   resp_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = '0;
   logic          mem_ack   = 1'b0;

   int tests = 0;
   int fails = 0;

   logic [31:0] ram [0:1023];
   logic [31:0] exp_ram [0:15];
   int          wait_target = 0;
   int          wait_cnt    = 0;
   bit          auto_ack    = 1'b1;
   bit          man_ack     = 1'b0;
   int          pl_seq      = 0;
   int          pl_seen     = 0;
   logic [9:0]  pl_addr     = '0;
   logic [31:0] pl_data     = '0;

   always #5 clk = ~clk;

   lsu_mem_master #(.ADDR_W(AW)) dut (
      .clk(clk), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   // RAM model: decides mem_ack for the coming edge; wait_target wait cycles per phase
   always @(negedge clk) begin
      if (pl_seq != pl_seen) begin
         ram[pl_addr] = pl_data;
         pl_seen = pl_seq;
      end
      if (!auto_ack) begin
         mem_ack   = man_ack;
         mem_rdata = 32'h0BAD_F00D;
         wait_cnt  = 0;
      end else begin
         if (mem_ack) wait_cnt = 0;
         if (mem_en && (wait_cnt >= wait_target)) begin
            mem_ack   = 1'b1;
            mem_rdata = ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
         end else begin
            mem_ack = 1'b0;
            if (mem_en) wait_cnt++;
            else        wait_cnt = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      pl_addr = idx[9:0];
      pl_data = d;
      pl_seq++;
      repeat (2) @(negedge clk);
      #1;
   endtask

   // Spec-level access model: error, extended load data, resulting RAM word, latency
   function automatic void ref_model(input bit we, input bit [1:0] sz, input bit sgn,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     input logic [31:0] word, input int w,
                                     output logic [31:0] rd, output bit err,
                                     output logic [31:0] nw, output int lat);
      int unsigned nbytes, sh;
      logic [31:0] mask;
      err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
         || (a >= 32'd4096);
      rd  = '0;
      nw  = word;
      lat = 1;
      if (err) return;
      nbytes = 1 << sz;
      sh     = (a % 4) * 8;
      mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (nbytes * 8)) - 1);
      if (!we) begin
         rd = (word >> sh) & mask;
         if (sgn && nbytes < 4 && rd[nbytes*8-1]) rd = rd | ~mask;
         lat = 2 + w;
      end else begin
         nw  = (word & ~(mask << sh)) | ((wd & mask) << sh);
         lat = (nbytes == 4) ? 2 + w : 3 + 2 * w;
      end
   endfunction

   task automatic do_req(input bit we, input bit [1:0] sz, input bit sgn,
                         input logic [31:0] a, input logic [31:0] wd, input int waits,
                         output logic [31:0] rd, output logic e, output int lat,
                         output int en_cyc, output bit addr_bad);
      bit done;
      wait_target = waits;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      lat = 0; en_cyc = 0; addr_bad = 1'b0; done = 1'b0; rd = '0; e = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         lat++;
         if (mem_en) begin
            en_cyc++;
            if (mem_addr != a[11:2]) addr_bad = 1'b1;
         end
         if (resp_valid) begin
            rd = resp_rdata; e = resp_err; done = 1'b1;
         end
      end
      check("resp_timeout", 32'(done), 32'd1);
   endtask

   typedef struct {
      bit          we;
      bit [1:0]    size;
      bit          sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pre;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          exp_lat;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [12];

   logic [31:0] rd, exp_rd, exp_nw;
   logic        e;
   bit          exp_e, abad;
   int          lat, exp_lat, encyc;

   initial begin
      vecs[0]  = '{0, 2'd0, 1, 32'h0E, 32'h0,        32'h8899AABB, 32'hFFFFFF99, 0, 2, 32'h8899AABB};
      vecs[1]  = '{0, 2'd0, 0, 32'h0E, 32'h0,        32'h8899AABB, 32'h00000099, 0, 2, 32'h8899AABB};
      vecs[2]  = '{1, 2'd1, 0, 32'h0C, 32'h00001234, 32'h8899AABB, 32'h00000000, 0, 3, 32'h88991234};
      vecs[3]  = '{0, 2'd2, 0, 32'h06, 32'h0,        32'h55555555, 32'h00000000, 1, 1, 32'h55555555};
      vecs[4]  = '{0, 2'd1, 0, 32'h01, 32'h0,        32'h66666666, 32'h00000000, 1, 1, 32'h66666666};
      vecs[5]  = '{0, 2'd3, 0, 32'h04, 32'h0,        32'h77777777, 32'h00000000, 1, 1, 32'h77777777};
      vecs[6]  = '{0, 2'd2, 0, 32'h1000, 32'h0,      32'h12121212, 32'h00000000, 1, 1, 32'h12121212};
      vecs[7]  = '{0, 2'd1, 1, 32'h0E, 32'h0,        32'h8899AABB, 32'hFFFF8899, 0, 2, 32'h8899AABB};
      vecs[8]  = '{0, 2'd1, 0, 32'h0C, 32'h0,        32'h8899AABB, 32'h0000AABB, 0, 2, 32'h8899AABB};
      vecs[9]  = '{0, 2'd2, 1, 32'h0C, 32'h0,        32'h8899AABB, 32'h8899AABB, 0, 2, 32'h8899AABB};
      vecs[10] = '{1, 2'd0, 1, 32'h0D, 32'h123456CD, 32'h8899AABB, 32'h00000000, 0, 3, 32'h8899CDBB};
      vecs[11] = '{1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 0, 2, 32'hDEADBEEF};

      clr = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp", {29'd0, resp_valid, resp_err, mem_en}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      repeat (2) @(negedge clk);
      clr = 1'b0;

      // Directed table, zero-wait RAM
      for (int i = 0; i < 12; i++) begin
         preload(int'(vecs[i].addr[11:2]), vecs[i].pre);
         do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, 0,
                rd, e, lat, encyc, abad);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_ram", i), ram[vecs[i].addr[11:2]], vecs[i].exp_word);
         check($sformatf("vec%0d_en_cycles", i), encyc, vecs[i].exp_err ? 0 : vecs[i].exp_lat - 1);
         check($sformatf("vec%0d_addr_stable", i), 32'(abad), 32'd0);
      end

      // Word store with a 3-cycle delayed ack
      wait_target = 3;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("sw_wait_en_we_resp", {29'd0, mem_en, mem_we, resp_valid}, 32'b110);
         check("sw_wait_addr", 32'(mem_addr), 32'd4);
      end
      @(negedge clk);
      check("sw_wait_resp", {30'd0, resp_valid, resp_err}, 32'b10);
      @(negedge clk);
      check("sw_wait_single_pulse", 32'(resp_valid), 32'd0);
      check("sw_wait_ram", ram[4], 32'hDEADBEEF);
      wait_target = 0;

      // Reset during WR, then a stray ack
      auto_ack = 1'b0; man_ack = 1'b0;
      preload(8, 32'h11112222);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rstwr_in_wr", {29'd0, mem_en, mem_we, req_ready}, 32'b110);
      #1 clr = 1'b1;
      #1;
      check("rstwr_req_ready", 32'(req_ready), 32'd1);
      check("rstwr_ctl", {28'd0, resp_valid, resp_err, mem_en, mem_we}, 32'd0);
      check("rstwr_rdata", resp_rdata, 32'd0);
      check("rstwr_mem_addr", 32'(mem_addr), 32'd0);
      check("rstwr_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      clr = 1'b0; man_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stray_ack_idle", {29'd0, req_ready, resp_valid, mem_en}, 32'b100);
      end
      man_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("rstwr_ram_kept", ram[8], 32'h11112222);
      auto_ack = 1'b1;
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, rd, e, lat, encyc, abad);
      check("after_rst_lw", rd, 32'h11112222);
      check("after_rst_lat", lat, 2);

      // Back-to-back with req_valid held high
      preload(5, 32'hCAFEF00D);
      preload(6, 32'h01020304);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h14;
      @(posedge clk);
      #1 req_size = 2'd0; req_addr = 32'h19;
      @(negedge clk);
      check("b2b_c1_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("b2b_c2_resp", {30'd0, resp_valid, req_ready}, 32'b10);
      check("b2b_c2_rdata", resp_rdata, 32'hCAFEF00D);
      @(negedge clk);
      check("b2b_c3_idle", {30'd0, resp_valid, req_ready}, 32'b01);
      @(negedge clk);
      check("b2b_c4_accepted", {29'd0, req_ready, mem_en, mem_we}, 32'b010);
      check("b2b_c4_addr", 32'(mem_addr), 32'd6);
      req_valid = 1'b0;
      @(negedge clk);
      check("b2b_c5_resp", 32'(resp_valid), 32'd1);
      check("b2b_c5_rdata", resp_rdata, 32'h00000003);
      @(negedge clk);
      check("b2b_c6_idle", {30'd0, resp_valid, req_ready}, 32'b01);

      // Randomized requests against the access model
      for (int i = 0; i < 16; i++) begin
         exp_ram[i] = $urandom;
         preload(i, exp_ram[i]);
      end
      for (int n = 0; n < 200; n++) begin
         bit          r_we, r_sgn;
         bit [1:0]    r_sz;
         int          idx, w;
         logic [31:0] a, wd;
         r_we  = 1'($urandom);
         r_sz  = 2'($urandom);
         r_sgn = 1'($urandom);
         idx   = $urandom_range(15, 0);
         a     = (idx * 4) + $urandom_range(3, 0);
         if ($urandom_range(7, 0) == 0) a = a | (32'd1 << $urandom_range(31, 12));
         wd    = $urandom;
         w     = $urandom_range(2, 0);
         ref_model(r_we, r_sz, r_sgn, a, wd, exp_ram[idx], w, exp_rd, exp_e, exp_nw, exp_lat);
         do_req(r_we, r_sz, r_sgn, a, wd, w, rd, e, lat, encyc, abad);
         exp_ram[idx] = exp_nw;
         check($sformatf("rnd%0d_rdata", n), rd, exp_rd);
         check($sformatf("rnd%0d_err", n), 32'(e), 32'(exp_e));
         check($sformatf("rnd%0d_lat", n), lat, exp_lat);
         check($sformatf("rnd%0d_ram", n), ram[idx], exp_ram[idx]);
         check($sformatf("rnd%0d_en_cycles", n), encyc, exp_e ? 0 : exp_lat - 1);
         check($sformatf("rnd%0d_addr_stable", n), 32'(abad), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
